// File: rtl/carry_seq.sv
// -----------------------------------------------------------------------------
// carry_seq
//
// Sequencer that walks one external slice adder across NUM_SLICES slices of a
// wide operation, LSB slice first. It supplies each slice with its carry-in
// and captures the slice carry-out so it can feed the next slice. The top
// slice carry is reported as final_cout together with a one-cycle done pulse.
//
// Parameters
//   NUM_SLICES  slices per wide operation (2..16)
//   CIN_OPS     bit k set: opsel value k starts with carry-in 1 (mode = 0 only)
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   start       request a new operation (only looked at in IDLE)
//   opsel       operation select, captured on an accepted start
//   mode        0 = arithmetic, 1 = logic (no carries), captured on start
//   abort       cancel the operation in flight (RUN only)
//   slice_cout  carry-out of the slice currently enabled
//   busy        high in RUN and DONE
//   slice_en    high while a slice is being evaluated
//   slice_idx   index of the slice being evaluated
//   slice_cin   carry-in for the slice being evaluated
//   done        one-cycle completion pulse
//   final_cout  carry-out of the top slice, held until the next completion
//
// Optional build feature
//   CARRY_SEQ_TRACE_EN  adds output carry_trace[NUM_SLICES-1:0], one bit per
//                       slice holding the carry-out seen for that slice.
// -----------------------------------------------------------------------------
module carry_seq #(
    parameter int         NUM_SLICES = 4,
    parameter logic [7:0] CIN_OPS    = 8'b0101_1000,
    localparam int        IDX_W      = $clog2(NUM_SLICES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       opsel,
    input  logic             mode,
    input  logic             abort,
    input  logic             slice_cout,
    output logic             busy,
    output logic             slice_en,
    output logic [IDX_W-1:0] slice_idx,
    output logic             slice_cin,
    output logic             done,
    output logic             final_cout
`ifdef CARRY_SEQ_TRACE_EN
    ,
    output logic [NUM_SLICES-1:0] carry_trace
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       opsel_q, opsel_d;
    logic             mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             final_q, final_d;
    logic             init_carry;
    logic             masked_cout;

`ifdef CARRY_SEQ_TRACE_EN
    logic [NUM_SLICES-1:0] trace_q, trace_d;
`endif

    // In logic mode no carry ever propagates, so the captured carry is forced
    // low; that keeps slice_cin and final_cout at 0 without extra gating.
    assign init_carry  = CIN_OPS[opsel_q] & ~mode_q;
    assign masked_cout = slice_cout & ~mode_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        opsel_d = opsel_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        final_d = final_q;
`ifdef CARRY_SEQ_TRACE_EN
        trace_d = trace_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    idx_d   = '0;
                    opsel_d = opsel;
                    mode_d  = mode;
`ifdef CARRY_SEQ_TRACE_EN
                    trace_d = '0;
`endif
                end
            end
            RUN: begin
                carry_d = masked_cout;
`ifdef CARRY_SEQ_TRACE_EN
                trace_d[idx_q] = slice_cout;
`endif
                // Abort wins over the last-slice transition; final_cout is
                // only touched on a completed operation.
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    idx_d   = '0;
                    final_d = masked_cout;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                // start is deliberately ignored here; the next accept can
                // only happen from IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            opsel_q <= '0;
            mode_q  <= 1'b0;
            carry_q <= 1'b0;
            final_q <= 1'b0;
`ifdef CARRY_SEQ_TRACE_EN
            trace_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            opsel_q <= opsel_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            final_q <= final_d;
`ifdef CARRY_SEQ_TRACE_EN
            trace_q <= trace_d;
`endif
        end
    end

    always_comb begin
        busy       = (state_q != IDLE);
        slice_en   = 1'b0;
        slice_idx  = '0;
        slice_cin  = 1'b0;
        done       = (state_q == DONE);
        final_cout = final_q;
        if (state_q == RUN) begin
            slice_en  = 1'b1;
            slice_idx = idx_q;
            slice_cin = (idx_q == '0) ? init_carry : carry_q;
        end
    end

`ifdef CARRY_SEQ_TRACE_EN
    assign carry_trace = trace_q;
`endif

endmodule

// File: tb/tb_carry_seq.sv
module tb_carry_seq;

    localparam int         N   = 4;
    localparam int         IW  = $clog2(N);
    localparam logic [7:0] CIN = 8'b0101_1000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [2:0]    opsel;
    logic          mode;
    logic          abort;
    logic          slice_cout;
    logic          busy;
    logic          slice_en;
    logic [IW-1:0] slice_idx;
    logic          slice_cin;
    logic          done;
    logic          final_cout;
`ifdef CARRY_SEQ_TRACE_EN
    logic [N-1:0]  carry_trace;
`endif

    int   checks   = 0;
    int   failures = 0;
    logic last_final;

    carry_seq #(.NUM_SLICES(N), .CIN_OPS(CIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .opsel      (opsel),
        .mode       (mode),
        .abort      (abort),
        .slice_cout (slice_cout),
        .busy       (busy),
        .slice_en   (slice_en),
        .slice_idx  (slice_idx),
        .slice_cin  (slice_cin),
        .done       (done),
        .final_cout (final_cout)
`ifdef CARRY_SEQ_TRACE_EN
        ,
        .carry_trace(carry_trace)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic b, input logic en,
                           input logic [IW-1:0] ix, input logic ci, input logic dn);
        logic [IW+3:0] obs;
        logic [IW+3:0] exp;
        obs = {busy, slice_en, slice_idx, slice_cin, done};
        exp = {b, en, ix, ci, dn};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s {busy,en,idx,cin,done} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_fc(input string tag, input logic e);
        checks++;
        assert (final_cout === e) else begin
            failures++;
            $error("FAIL %s final_cout observed=%b expected=%b", tag, final_cout, e);
        end
    endtask

    // One wide operation. Entered just after an edge with the DUT in IDLE.
    // Reference: slice 0 gets CIN[op] in arithmetic mode, slice i gets the
    // carry-out of slice i-1, logic mode zeroes every carry.
    task automatic run_op(input string tag, input logic [2:0] op, input logic md,
                          input logic [N-1:0] co, input int abort_at, input logic hold);
        logic [N-1:0] cin_exp;
        logic         fc_exp;
        cin_exp[0] = CIN[op] & ~md;
        for (int i = 1; i < N; i++) cin_exp[i] = co[i-1] & ~md;
        fc_exp = co[N-1] & ~md;

        chk_out({tag, "_idle"}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        start = 1'b1;
        opsel = op;
        mode  = md;
        tick;
        for (int i = 0; i < N; i++) begin
            chk_out($sformatf("%s_s%0d", tag, i), 1'b1, 1'b1, IW'(i), cin_exp[i], 1'b0);
            start      = hold ? 1'b1 : 1'($urandom_range(0, 1));
            opsel      = 3'($urandom);
            mode       = 1'($urandom);
            slice_cout = co[i];
            abort      = (i == abort_at);
            tick;
            if (i == abort_at) begin
                chk_out({tag, "_abort"}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
                chk_fc({tag, "_abort_fc"}, last_final);
                abort = 1'b0;
                start = 1'b0;
                return;
            end
        end
        chk_out({tag, "_done"}, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk_fc({tag, "_fc"}, fc_exp);
`ifdef CARRY_SEQ_TRACE_EN
        checks++;
        assert (carry_trace === co) else begin
            failures++;
            $error("FAIL %s_trace observed=%b expected=%b", tag, carry_trace, co);
        end
`endif
        last_final = fc_exp;
        abort = 1'($urandom_range(0, 1));
        start = hold ? 1'b1 : 1'($urandom_range(0, 1));
        tick;
        abort = 1'b0;
        chk_out({tag, "_after"}, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk_fc({tag, "_after_fc"}, last_final);
        if (!hold) start = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b1;
        abort      = 1'b1;
        opsel      = 3'b011;
        mode       = 1'b0;
        slice_cout = 1'b1;
        last_final = 1'b0;
        tick;
        tick;
        chk_out("reset", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk_fc("reset_fc", 1'b0);
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick;

        run_op("ex1", 3'b011, 1'b0, 4'b1101, -1, 1'b0);
        run_op("ex2", 3'b000, 1'b0, 4'b1111, -1, 1'b0);
        run_op("ex3", 3'b110, 1'b1, 4'b1111, -1, 1'b0);
        run_op("abort2", 3'b100, 1'b0, 4'b1111, 2, 1'b0);
        run_op("restart", 3'b100, 1'b0, 4'b0110, -1, 1'b0);
        run_op("hold1", 3'b001, 1'b0, 4'b1010, -1, 1'b1);
        run_op("hold2", 3'b011, 1'b0, 4'b0101, -1, 1'b1);
        start = 1'b0;

        // Reset in the middle of an operation at slice 1.
        chk_out("rstmid_idle", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        start = 1'b1;
        opsel = 3'b011;
        mode  = 1'b0;
        tick;
        start      = 1'b0;
        slice_cout = 1'b1;
        tick;
        chk_out("rstmid_s1", 1'b1, 1'b1, IW'(1), 1'b1, 1'b0);
        rst   = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick;
        chk_out("rstmid_out", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk_fc("rstmid_fc", 1'b0);
        last_final = 1'b0;
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        tick;
        chk_out("rstmid_nodone", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        run_op("postrst", 3'b011, 1'b0, 4'b1101, -1, 1'b0);

        for (int k = 0; k < 24; k++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            run_op($sformatf("rnd%0d", k), 3'($urandom), 1'($urandom), N'($urandom), ab, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/carry_seq.md
CARRY_SEQ -- requirements
Module: carry_seq

Interface
REQ-001 Parameter NUM_SLICES, default 4, number of adder slices per wide operation; legal range 2..16.
REQ-002 Parameter CIN_OPS, default 8'b0101_1000, bit k = 1 means opsel value k takes carry-in 1 when mode = 0.
REQ-003 Derived localparam IDX_W = $clog2(NUM_SLICES).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 start  in  1  request a new wide operation; sampled only in IDLE.
REQ-007 opsel  in  3  operation select; captured on an accepted start.
REQ-008 mode  in  1  0 = arithmetic, 1 = logic; captured on an accepted start.
REQ-009 abort  in  1  cancel an in-flight operation.
REQ-010 slice_cout  in  1  carry-out of the external slice adder for the slice currently enabled.
REQ-011 busy  out  1  high in RUN and DONE.
REQ-012 slice_en  out  1  high while a slice is being evaluated.
REQ-013 slice_idx  out  IDX_W  index of the slice currently evaluated, LSB slice = 0.
REQ-014 slice_cin  out  1  carry-in for the current slice.
REQ-015 done  out  1  one-cycle completion pulse.
REQ-016 final_cout  out  1  carry-out of the top slice; valid while done = 1 and held until the next accepted start.

Function
REQ-017 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-018 IDLE SHALL go to RUN when start = 1, and SHALL latch opsel and mode, and set idx = 0.
REQ-019 Initial carry SHALL be CIN_OPS[opsel] AND (mode = 0), computed from the latched values.
REQ-020 In RUN, slice_en SHALL be 1 and slice_idx SHALL equal idx.
REQ-021 In RUN, slice_cin SHALL equal the initial carry when idx = 0, and the registered slice_cout of slice idx-1 otherwise.
REQ-022 When mode = 1, slice_cin SHALL be 0 for every slice and final_cout SHALL be 0, regardless of slice_cout.
REQ-023 Each RUN cycle SHALL register slice_cout and increment idx.
REQ-024 When idx = NUM_SLICES-1, RUN SHALL go to DONE; idx SHALL never exceed NUM_SLICES-1.
REQ-025 DONE SHALL last exactly one cycle with done = 1 and final_cout = the last registered carry, then return to IDLE.
REQ-026 Latency: start accepted at edge t puts slice 0 at cycle t+1, slice NUM_SLICES-1 at cycle t+NUM_SLICES, and done at cycle t+NUM_SLICES+1.
REQ-027 start asserted in RUN or DONE SHALL be ignored, with no queuing.
REQ-028 start asserted in the cycle done = 1 SHALL be ignored; the earliest next accept is the following IDLE cycle.
REQ-029 abort = 1 in RUN SHALL force IDLE at the next edge, with no done pulse and final_cout unchanged.
REQ-030 abort SHALL take priority over the RUN-to-DONE transition, and SHALL have no effect in IDLE or DONE.
REQ-031 Outside RUN, slice_en, slice_cin and slice_idx SHALL be 0.

Reset
REQ-032 rst = 1 SHALL force, at the next edge: state IDLE, idx 0, busy 0, slice_en 0, slice_cin 0, done 0, final_cout 0, and the carry register 0.
REQ-033 rst SHALL override start and abort in the same cycle.
REQ-034 rst mid-operation SHALL discard the operation with no done pulse.

Configuration
REQ-035 With macro CARRY_SEQ_TRACE_EN defined, the block SHALL add output carry_trace [NUM_SLICES-1:0].
REQ-036 Bit i of carry_trace SHALL be the slice_cout registered for slice i; the vector SHALL be valid with done and held until the next accepted start.
REQ-037 carry_trace SHALL be cleared by rst and on an accepted start.
REQ-038 Without CARRY_SEQ_TRACE_EN, the port and its storage SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 NUM_SLICES=4, opsel=3'b011, mode=0, slice_cout=1,0,1,1 -> slice_cin=1,1,0,1; done at cycle t+5; final_cout=1; carry_trace=4'b1101.
REQ-040 opsel=3'b000, mode=0, slice_cout all 1 -> slice_cin=0,1,1,1; final_cout=1.
REQ-041 opsel=3'b110, mode=1, slice_cout all 1 -> slice_cin all 0; final_cout=0.
REQ-042 abort asserted at slice_idx=2 -> IDLE next cycle, no done pulse, busy falls; a fresh start then restarts at idx 0.
REQ-043 start held high continuously -> back-to-back operations separated by exactly one IDLE cycle; no start accepted during RUN or DONE.
REQ-044 rst asserted at slice_idx=1 -> all outputs 0 next cycle; no done pulse; the next start behaves as from power-up.
